prio_arb_enc: RTL and testbench

Parametrised, registered priority encoder/arbiter that generalises the 8-to-3 priority encoder. It captures single-cycle request pulses from N sources into a sticky pending register and selects one pending source per transfer, by fixed priority (highest index wins) or round-robin. It presents the winner's binary index and one-hot grant behind a valid/ack handshake. It sits between interrupt/event sources and a single consumer that services one source at a time.

---
 rtl/prio_arb_enc.sv | 96 +++++++++
 tb/tb_prio_arb_enc.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_arb_enc.sv
// prio_arb_enc: registered N-input priority encoder / arbiter.
// Single-cycle request pulses are held in a sticky pending register. One
// pending source per transfer is picked by fixed priority (MODE=0, highest
// index wins) or round-robin (MODE=1). The winner is presented as a binary
// index plus a one-hot grant behind a valid/ack handshake.
module prio_arb_enc #(
    parameter int N    = 8,
    parameter int MODE = 0,
    localparam int W   = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    input  logic         ack,
    output logic         v_out,
    output logic [W-1:0] out,
    output logic [N-1:0] grant
);

    logic [N-1:0] pend;
    logic [W-1:0] ptr;

    logic [N-1:0] cand;
    logic         load;
    logic [W-1:0] sel_fp;
    logic [W-1:0] sel_rr;
    logic [W-1:0] sel;
    logic [N-1:0] rot;
    logic [W-1:0] rot_idx;
    logic [W:0]   rr_sum;
    logic [N-1:0] grant_new;

    // Candidate set and load decision: a new winner may only enter an empty
    // slot or one being acked this cycle.
    always_comb begin
        cand = pend | (en ? req : '0);
        load = en && (!v_out || ack) && (cand != '0);
    end

    // Fixed priority: the highest set index of the candidate set.
    always_comb begin
        sel_fp = '0;
        for (int i = 0; i < N; i++) begin
            if (cand[i]) sel_fp = W'(i);
        end
    end

    // Round-robin: rotate cand right by ptr so bit N-1 of rot lines up with
    // index ptr-1 (the highest-priority slot) and bit 0 with ptr itself (the
    // last winner, lowest priority). A plain highest-bit scan of rot then
    // gives the winner's offset, which is rotated back modulo N.
    always_comb begin
        rot     = N'({cand, cand} >> ptr);
        rot_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (rot[i]) rot_idx = W'(i);
        end
        rr_sum = {1'b0, rot_idx} + {1'b0, ptr};
        if (rr_sum >= (W+1)'(N)) rr_sum = rr_sum - (W+1)'(N);
        sel_rr = rr_sum[W-1:0];
    end

    // Mode select and one-hot of the new winner.
    always_comb begin
        sel       = (MODE == 1) ? sel_rr : sel_fp;
        grant_new = {{(N-1){1'b0}}, 1'b1} << sel;
    end

    // Output slot, pending register and round-robin pointer. A pulse on the
    // bit currently held in the slot stays in pend because only the newly
    // selected bit is removed on a load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend  <= '0;
            ptr   <= '0;
            v_out <= 1'b0;
            out   <= '0;
            grant <= '0;
        end else if (load) begin
            v_out <= 1'b1;
            out   <= sel;
            grant <= grant_new;
            pend  <= cand & ~grant_new;
            if (MODE == 1) ptr <= sel;
        end else begin
            if (en) pend <= cand;
            if (ack && v_out) begin
                v_out <= 1'b0;
                out   <= '0;
                grant <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prio_arb_enc.sv
// Bench for prio_arb_enc: three instances (N=8 fixed, N=8 round-robin,
// N=16 fixed) share en/ack/rst, each with its own request vector. A
// behavioural model of each instance is stepped every cycle and compared
// against all outputs, on top of directed scenarios with explicit values.
module tb_prio_arb_enc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic        ack = 1'b0;
    logic [7:0]  r0  = '0;
    logic [7:0]  r1  = '0;
    logic [15:0] r2  = '0;

    logic        v0, v1, v2;
    logic [2:0]  o0, o1;
    logic [3:0]  o2;
    logic [7:0]  g0, g1;
    logic [15:0] g2;

    int total = 0;
    int bad   = 0;

    prio_arb_enc #(.N(8),  .MODE(0)) u0 (.clk(clk), .rst(rst), .en(en), .req(r0), .ack(ack),
                                         .v_out(v0), .out(o0), .grant(g0));
    prio_arb_enc #(.N(8),  .MODE(1)) u1 (.clk(clk), .rst(rst), .en(en), .req(r1), .ack(ack),
                                         .v_out(v1), .out(o1), .grant(g1));
    prio_arb_enc #(.N(16), .MODE(0)) u2 (.clk(clk), .rst(rst), .en(en), .req(r2), .ack(ack),
                                         .v_out(v2), .out(o2), .grant(g2));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] m_pend [3];
    logic        m_v    [3];
    int          m_out  [3];
    int          m_ptr  [3];

    function automatic int n_of(input int k);
        return (k == 2) ? 16 : 8;
    endfunction

    function automatic logic [15:0] req_of(input int k);
        case (k)
            0:       return {8'h00, r0};
            1:       return {8'h00, r1};
            default: return r2;
        endcase
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 3; k++) begin
            m_pend[k] = '0;
            m_v[k]    = 1'b0;
            m_out[k]  = 0;
            m_ptr[k]  = 0;
        end
    endtask

    // Round-robin priority of index i: the last winner (ptr) ranks lowest,
    // ptr-1 ranks highest, i.e. rank = (i - ptr) mod n.
    task automatic m_step(input int k);
        int          n;
        int          best;
        int          bestp;
        int          p;
        logic [15:0] cand;
        n     = n_of(k);
        cand  = m_pend[k] | (en ? req_of(k) : 16'h0);
        best  = -1;
        bestp = -1;
        if (en && (!m_v[k] || ack) && cand != 16'h0) begin
            for (int i = 0; i < n; i++) begin
                if (cand[i]) begin
                    p = (k == 1) ? (i - m_ptr[k] + n) % n : i;
                    if (p > bestp) begin
                        bestp = p;
                        best  = i;
                    end
                end
            end
            m_v[k]    = 1'b1;
            m_out[k]  = best;
            m_pend[k] = cand & ~(16'h1 << best);
            if (k == 1) m_ptr[k] = best;
        end else begin
            if (en) m_pend[k] = cand;
            if (ack && m_v[k]) begin
                m_v[k]   = 1'b0;
                m_out[k] = 0;
            end
        end
    endtask

    task automatic m_check(input int k);
        logic        av;
        logic [15:0] ao;
        logic [15:0] ag;
        logic [15:0] eg;
        case (k)
            0:       begin av = v0; ao = {13'b0, o0}; ag = {8'b0, g0}; end
            1:       begin av = v1; ao = {13'b0, o1}; ag = {8'b0, g1}; end
            default: begin av = v2; ao = {12'b0, o2}; ag = g2;         end
        endcase
        eg = m_v[k] ? (16'h1 << m_out[k]) : 16'h0;
        chk($sformatf("u%0d.v_out", k), {63'b0, av}, {63'b0, m_v[k]});
        chk($sformatf("u%0d.out", k),   {48'b0, ao}, 64'(m_out[k]));
        chk($sformatf("u%0d.grant", k), {48'b0, ag}, {48'b0, eg});
    endtask

    // One clock: the model consumes the inputs seen at the edge, outputs are
    // compared 1 time unit later. Callers change inputs after this returns.
    task automatic tick();
        @(posedge clk);
        if (rst) m_reset();
        else for (int k = 0; k < 3; k++) m_step(k);
        #1;
        for (int k = 0; k < 3; k++) m_check(k);
    endtask

    // Reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        #3 rst = 1'b1;
        #1;
        m_reset();
        for (int k = 0; k < 3; k++) m_check(k);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #1;
        do_reset();

        // idle after reset
        repeat (5) begin
            tick();
            chk("idle.v", {61'b0, v0, v1, v2}, 64'h0);
        end

        // fixed priority on u0
        en = 1'b1; ack = 1'b0; r0 = 8'b0010_0110;
        tick();
        r0 = 8'h00;
        chk("fp.out", 64'(o0), 64'd5);
        chk("fp.grant", 64'(g0), 64'h20);
        repeat (2) begin
            tick();
            chk("fp.hold.out", 64'(o0), 64'd5);
            chk("fp.hold.grant", 64'(g0), 64'h20);
        end
        ack = 1'b1;
        tick(); chk("fp.out2", 64'(o0), 64'd2);
        tick(); chk("fp.out1", 64'(o0), 64'd1);
        tick(); chk("fp.drain.v", 64'(v0), 64'd0);
        ack = 1'b0;

        // round-robin on u1, all requesters
        do_reset();
        en = 1'b1; ack = 1'b1; r1 = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rr.ff.out", 64'(o1), 64'(7 - (i % 8)));
        end
        r1 = 8'h00;
        do_reset();
        r1 = 8'h81;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr.81.out", 64'(o1), (i % 2) ? 64'd0 : 64'd7);
        end
        r1 = 8'h00;
        repeat (3) tick();
        ack = 1'b0;

        // enable gating
        do_reset();
        en = 1'b0; r0 = 8'h10;
        tick();
        r0 = 8'h00;
        chk("en0.nocap", 64'(v0), 64'd0);
        tick(); chk("en0.nocap2", 64'(v0), 64'd0);
        en = 1'b1;
        tick(); chk("en0.nocap3", 64'(v0), 64'd0);
        r0 = 8'h0C;
        tick();
        r0 = 8'h00;
        chk("en.sel3", 64'(o0), 64'd3);
        en = 1'b0; ack = 1'b1;
        tick(); chk("en0.ackclr", 64'(v0), 64'd0);
        ack = 1'b0;
        tick(); chk("en0.hold", 64'(v0), 64'd0);
        en = 1'b1;
        tick();
        chk("en1.resume.v", 64'(v0), 64'd1);
        chk("en1.resume.out", 64'(o0), 64'd2);
        ack = 1'b1;
        tick(); chk("en1.drain", 64'(v0), 64'd0);
        ack = 1'b0;

        // coalescing: bit 3 pulsed twice while pending
        r0 = 8'h80;
        tick(); chk("co.out7", 64'(o0), 64'd7);
        r0 = 8'h08; tick();
        r0 = 8'h08; tick();
        r0 = 8'h00; ack = 1'b1;
        tick(); chk("co.out3", 64'(o0), 64'd3);
        tick(); chk("co.single", 64'(v0), 64'd0);
        ack = 1'b0;

        // re-request of the granted bit
        r0 = 8'h08;
        tick(); chk("rq.out3", 64'(o0), 64'd3);
        tick(); chk("rq.hold", 64'(o0), 64'd3);
        r0 = 8'h00; ack = 1'b1;
        tick();
        chk("rq.again.v", 64'(v0), 64'd1);
        chk("rq.again.grant", 64'(g0), 64'h08);
        tick(); chk("rq.done", 64'(v0), 64'd0);
        ack = 1'b0;

        // reset mid-operation on the 16-wide instance
        r2 = 16'h8421;
        tick();
        r2 = 16'h0000;
        chk("mr.out15", 64'(o2), 64'd15);
        tick();
        do_reset();
        chk("mr.v", 64'(v2), 64'd0);
        chk("mr.grant", 64'(g2), 64'd0);
        ack = 1'b1;
        repeat (5) begin
            tick();
            chk("mr.nogrant", 64'(v2), 64'd0);
        end

        // randomized traffic against the model
        repeat (1500) begin
            en  = ($urandom_range(0, 9) != 0);
            ack = $urandom_range(0, 1) == 1;
            r0  = ($urandom_range(0, 3) == 0) ? 8'($urandom)  : 8'h00;
            r1  = ($urandom_range(0, 2) == 0) ? 8'($urandom)  : 8'h00;
            r2  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0000;
            if ($urandom_range(0, 299) == 0) do_reset();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
